// File: rtl/fetch_pc_unit_if.sv
// fetch_pc_unit_if
//   Instruction-memory request/acknowledge bus between the fetch stage and
//   the instruction memory. One request may be outstanding at a time; the
//   address is held stable from request until acknowledge.
// Signals
//   imem_req   fetch request (master -> slave)
//   imem_addr  fetch address (master -> slave)
//   imem_ack   response valid, completes the request (slave -> master)
//   imem_rdata fetched instruction (slave -> master)
interface fetch_pc_unit_if #(
  parameter int PC_W    = 16,
  parameter int INSTR_W = 16
);
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit
//   Program-counter and instruction-fetch stage. Takes resolved branch and
//   jump redirects, computes the next PC, issues fetches on a req/ack
//   instruction-memory bus and hands {instr, pc} to decode through a
//   2-entry output FIFO. A redirect flushes the FIFO and discards the
//   response to any request still in flight.
// Configuration
//   BR_STATS_EN : when defined, o_taken_cnt counts redirect cycles
//                 (saturating at 16'hFFFF, cleared only by reset); when
//                 undefined the counter is absent and o_taken_cnt is 0.
// Ports
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   i_brValid/i_bSel   conditional branch resolved / taken
//   i_brPC/i_brOffset  branch PC and sign-extended offset
//   i_jmpValid         unconditional jump this cycle
//   i_jmpTarget        jump destination
//   i_stall            decode cannot accept the FIFO head
//   imem               instruction-memory bus (master side)
//   o_if_valid         FIFO head valid
//   o_if_instr/o_if_pc FIFO head instruction / PC (hold last when empty)
//   o_flush            redirect taken this cycle (combinational)
//   o_taken_cnt        redirect count (see Configuration)
module fetch_pc_unit #(
  parameter int              PC_W     = 16,
  parameter int              INSTR_W  = 16,
  parameter int              STEP     = 2,
  parameter logic [PC_W-1:0] RESET_PC = 16'h0000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_brValid,
  input  logic               i_bSel,
  input  logic [PC_W-1:0]    i_brPC,
  input  logic [PC_W-1:0]    i_brOffset,
  input  logic               i_jmpValid,
  input  logic [PC_W-1:0]    i_jmpTarget,
  input  logic               i_stall,
  fetch_pc_unit_if.master    imem,
  output logic               o_if_valid,
  output logic [INSTR_W-1:0] o_if_instr,
  output logic [PC_W-1:0]    o_if_pc,
  output logic               o_flush,
  output logic [15:0]        o_taken_cnt
);

  localparam logic [PC_W-1:0] STEP_V = PC_W'(STEP);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [PC_W-1:0]    r_pc;
  logic [PC_W-1:0]    w_pc_nxt;
  logic [PC_W-1:0]    r_drain_addr;
  logic               w_req;
  logic [PC_W-1:0]    w_addr;

  logic               w_br_taken;
  logic               w_taken;
  logic [PC_W-1:0]    w_target;

  logic               r_hd_vld;
  logic               r_tl_vld;
  logic [INSTR_W-1:0] r_hd_instr;
  logic [PC_W-1:0]    r_hd_pc;
  logic [INSTR_W-1:0] r_tl_instr;
  logic [PC_W-1:0]    r_tl_pc;

  logic               w_ack;
  logic               w_pop;
  logic               w_push;
  logic [1:0]         w_cnt;
  logic [1:0]         w_cnt_pop;
  logic [1:0]         w_cnt_nxt;
  logic               w_hd_from_tl;
  logic               w_hd_from_in;
  logic               w_tl_from_in;

  // Redirect decode: the branch is older than the jump, so it wins.
  assign w_br_taken = i_brValid & i_bSel;
  assign w_taken    = w_br_taken | i_jmpValid;
  assign w_target   = w_br_taken ? (i_brPC + i_brOffset) : i_jmpTarget;

  assign w_ack     = imem.imem_ack;
  assign w_pop     = r_hd_vld & ~i_stall;
  // A response is only kept when it belongs to the current PC stream.
  assign w_push    = (r_state == S_FETCH) & w_ack & ~w_taken;
  assign w_cnt     = {1'b0, r_hd_vld} + {1'b0, r_tl_vld};
  assign w_cnt_pop = w_cnt - {1'b0, w_pop};
  assign w_cnt_nxt = w_taken ? 2'd0 : (w_cnt_pop + {1'b0, w_push});

  // Head/tail shift structure keeps the head registers holding the last
  // delivered entry once the FIFO drains.
  assign w_hd_from_tl = ~w_taken & w_pop & r_tl_vld;
  assign w_hd_from_in = w_push & (~r_hd_vld | (w_pop & ~r_tl_vld));
  assign w_tl_from_in = w_push & r_hd_vld & ~(w_pop & ~r_tl_vld);

  // ---- FSM: next state, next PC and bus outputs ----
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_req       = 1'b0;
    w_addr      = r_pc;
    case (r_state)
      S_IDLE: begin
        if (w_taken) begin
          w_pc_nxt    = w_target;
          w_state_nxt = S_FETCH;
        end else if (w_cnt_pop < 2'd2) begin
          w_state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        w_req = 1'b1;
        if (w_taken) begin
          w_pc_nxt    = w_target;
          w_state_nxt = w_ack ? S_FETCH : S_DRAIN;
        end else if (w_ack) begin
          w_pc_nxt    = r_pc + STEP_V;
          // The pushed entry plus one new request must fit in two slots.
          w_state_nxt = (w_cnt_pop == 2'd0) ? S_FETCH : S_IDLE;
        end
      end
      S_DRAIN: begin
        w_req  = 1'b1;
        w_addr = r_drain_addr;
        if (w_taken) begin
          w_pc_nxt = w_target;
        end
        // FIFO was cleared on entry and nothing is pushed while draining,
        // so a fresh request always has credit.
        if (w_ack) begin
          w_state_nxt = S_FETCH;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ---- FSM state and PC registers ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  // Address of the abandoned request, held on the bus until it is acked.
  always_ff @(posedge clk) begin
    if ((r_state == S_FETCH) && w_taken && !w_ack) begin
      r_drain_addr <= r_pc;
    end
  end

  // ---- Output FIFO ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hd_vld <= 1'b0;
      r_tl_vld <= 1'b0;
    end else begin
      r_hd_vld <= (w_cnt_nxt != 2'd0);
      r_tl_vld <= (w_cnt_nxt == 2'd2);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hd_instr <= '0;
      r_hd_pc    <= '0;
    end else if (w_hd_from_tl) begin
      r_hd_instr <= r_tl_instr;
      r_hd_pc    <= r_tl_pc;
    end else if (w_hd_from_in) begin
      r_hd_instr <= imem.imem_rdata;
      r_hd_pc    <= r_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (w_tl_from_in) begin
      r_tl_instr <= imem.imem_rdata;
      r_tl_pc    <= r_pc;
    end
  end

  // ---- Redirect statistics ----
`ifdef BR_STATS_EN
  logic [15:0] r_taken_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_taken_cnt <= 16'h0000;
    end else if (w_taken && (r_taken_cnt != 16'hFFFF)) begin
      r_taken_cnt <= r_taken_cnt + 16'd1;
    end
  end

  assign o_taken_cnt = r_taken_cnt;
`else
  assign o_taken_cnt = 16'h0000;
`endif

  assign imem.imem_req  = w_req;
  assign imem.imem_addr = w_addr;
  assign o_if_valid     = r_hd_vld;
  assign o_if_instr     = r_hd_instr;
  assign o_if_pc        = r_hd_pc;
  assign o_flush        = w_taken;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit
//   Directed bench for fetch_pc_unit. A responder answers every request in
//   the cycle it is seen (instr = addr ^ 16'h5A00) unless manual control is
//   selected; a monitor logs accepted addresses and popped FIFO entries.
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        brValid, bSel, jmpValid, stall;
  logic [15:0] brPC, brOffset, jmpTarget;
  logic        if_valid, flush;
  logic [15:0] if_instr, if_pc, taken_cnt;

  logic        auto_ack;
  logic        man_ack;
  logic [15:0] man_rdata;

  logic [15:0] acc_q[$];
  logic [31:0] pop_q[$];

  int n_chk = 0;
  int n_bad = 0;

  fetch_pc_unit_if #(.PC_W(16), .INSTR_W(16)) imem_bus ();

  fetch_pc_unit #(
    .PC_W(16), .INSTR_W(16), .STEP(2), .RESET_PC(16'h0000)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_brValid  (brValid),
    .i_bSel     (bSel),
    .i_brPC     (brPC),
    .i_brOffset (brOffset),
    .i_jmpValid (jmpValid),
    .i_jmpTarget(jmpTarget),
    .i_stall    (stall),
    .imem       (imem_bus),
    .o_if_valid (if_valid),
    .o_if_instr (if_instr),
    .o_if_pc    (if_pc),
    .o_flush    (flush),
    .o_taken_cnt(taken_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory responder: runs after stimulus in each cycle.
  initial begin
    imem_bus.imem_ack   = 1'b0;
    imem_bus.imem_rdata = 16'h0000;
    forever begin
      @(posedge clk);
      #2;
      if (auto_ack) begin
        imem_bus.imem_ack   = imem_bus.imem_req;
        imem_bus.imem_rdata = imem_bus.imem_addr ^ 16'h5A00;
      end else begin
        imem_bus.imem_ack   = man_ack;
        imem_bus.imem_rdata = man_rdata;
      end
    end
  end

  // Monitor: accepted fetch addresses and entries delivered to decode.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (imem_bus.imem_req && imem_bus.imem_ack) acc_q.push_back(imem_bus.imem_addr);
        if (if_valid && !stall) pop_q.push_back({if_instr, if_pc});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nd;
    logic [15:0] exp_cnt;
    rst_n = 1'b0; brValid = 0; bSel = 0; jmpValid = 0; stall = 0;
    brPC = 0; brOffset = 0; jmpTarget = 0;
    auto_ack = 1'b1; man_ack = 1'b0; man_rdata = 16'h0000;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_req",    32'(imem_bus.imem_req),  32'h0);
    chk("rst_addr",   32'(imem_bus.imem_addr), 32'h0);
    chk("rst_valid",  32'(if_valid),           32'h0);
    chk("rst_instr",  32'(if_instr),           32'h0);
    chk("rst_pc",     32'(if_pc),              32'h0);
    chk("rst_taken",  32'(taken_cnt),          32'h0);
    chk("rst_flush",  32'(flush),              32'h0);

    // 1: sequential fetch with immediate acks
    tick(); rst_n = 1'b1;
    repeat (8) tick();
    @(negedge clk);
    chk("t1_nacc", 32'(acc_q.size() >= 3), 32'h1);
    chk("t1_acc0", 32'(acc_q[0]), 32'h0000);
    chk("t1_acc1", 32'(acc_q[1]), 32'h0002);
    chk("t1_acc2", 32'(acc_q[2]), 32'h0004);
    chk("t1_npop", 32'(pop_q.size() >= 3), 32'h1);
    chk("t1_pop0", pop_q[0], 32'h5A00_0000);
    chk("t1_pop1", pop_q[1], 32'h5A02_0002);
    chk("t1_pop2", pop_q[2], 32'h5A04_0004);

    // 2: taken branch 0x0010 + 0xFFF8 -> 0x0008
    tick(); brValid = 1; bSel = 1; brPC = 16'h0010; brOffset = 16'hFFF8;
    @(negedge clk);
    chk("t2_flush", 32'(flush), 32'h1);
    tick(); brValid = 0; bSel = 0;
    @(negedge clk);
    chk("t2_empty", 32'(if_valid), 32'h0);
    chk("t2_req",   32'(imem_bus.imem_req),  32'h1);
    chk("t2_addr",  32'(imem_bus.imem_addr), 32'h0008);
    tick(); auto_ack = 1'b0; man_ack = 1'b0;
    @(negedge clk);
    chk("t2_hdpc",  32'(if_pc),    32'h0008);
    chk("t2_hdvld", 32'(if_valid), 32'h1);

    // 3: jump to 0x0040 with request to 0x000A outstanding, late 0xDEAD ack
    tick(); jmpValid = 1; jmpTarget = 16'h0040; pop_q.delete();
    @(negedge clk);
    chk("t3_flush", 32'(flush), 32'h1);
    chk("t3_addr0", 32'(imem_bus.imem_addr), 32'h000A);
    tick(); jmpValid = 0;
    @(negedge clk);
    chk("t3_dreq",  32'(imem_bus.imem_req),  32'h1);
    chk("t3_daddr", 32'(imem_bus.imem_addr), 32'h000A);
    tick();
    tick(); man_ack = 1'b1; man_rdata = 16'hDEAD;
    @(negedge clk);
    chk("t3_aaddr", 32'(imem_bus.imem_addr), 32'h000A);
    tick(); man_ack = 1'b0;
    @(negedge clk);
    chk("t3_nreq",  32'(imem_bus.imem_req),  32'h1);
    chk("t3_naddr", 32'(imem_bus.imem_addr), 32'h0040);
    tick(); auto_ack = 1'b1;
    repeat (4) tick();
    @(negedge clk);
    nd = 0;
    foreach (pop_q[i]) if (pop_q[i][31:16] == 16'hDEAD) nd++;
    chk("t3_nodead", 32'(nd), 32'h0);
    chk("t3_pop0",   pop_q[0], 32'h5A40_0040);

    // 4: stall with continuous acks, then release
    tick(); jmpValid = 1; jmpTarget = 16'h0100; stall = 1;
    @(negedge clk);
    chk("t4_flush", 32'(flush), 32'h1);
    tick(); jmpValid = 0;
    repeat (4) tick();
    @(negedge clk);
    chk("t4_req",   32'(imem_bus.imem_req), 32'h0);
    chk("t4_vld",   32'(if_valid), 32'h1);
    chk("t4_hpc",   32'(if_pc),    32'h0100);
    chk("t4_hins",  32'(if_instr), 32'h5B00);
    tick(); stall = 0; pop_q.delete();
    repeat (6) tick();
    @(negedge clk);
    chk("t4_pop0", pop_q[0], 32'h5B00_0100);
    chk("t4_pop1", pop_q[1], 32'h5B02_0102);
    chk("t4_pop2", pop_q[2], 32'h5B04_0104);
    chk("t4_pop3", pop_q[3], 32'h5B06_0106);

    // 5: branch and jump together -> branch wins; not-taken branch -> no flush
    tick(); brValid = 1; bSel = 1; brPC = 16'h0010; brOffset = 16'h0010;
    jmpValid = 1; jmpTarget = 16'h0080;
    @(negedge clk);
    chk("t5_flush", 32'(flush), 32'h1);
    tick(); bSel = 0; jmpValid = 0;
    @(negedge clk);
    chk("t5_noflush", 32'(flush), 32'h0);
    chk("t5_addr",    32'(imem_bus.imem_addr), 32'h0020);
    tick(); brValid = 0;
    @(negedge clk);
    chk("t5_addr2",   32'(imem_bus.imem_addr), 32'h0022);

    // 6: PC wrap 0xFFFE -> 0x0000
    tick(); jmpValid = 1; jmpTarget = 16'hFFFE;
    tick(); jmpValid = 0;
    @(negedge clk);
    chk("t6_addr", 32'(imem_bus.imem_addr), 32'hFFFE);
    tick();
    @(negedge clk);
    chk("t6_wrap", 32'(imem_bus.imem_addr), 32'h0000);

    // Reset mid-fetch abandons the request
    tick(); rst_n = 1'b0;
    #1;
    chk("r2_req",   32'(imem_bus.imem_req),  32'h0);
    chk("r2_addr",  32'(imem_bus.imem_addr), 32'h0);
    chk("r2_valid", 32'(if_valid),           32'h0);
    chk("r2_pc",    32'(if_pc),              32'h0);
    chk("r2_taken", 32'(taken_cnt),          32'h0);

    // Three redirects for the statistics counter
    tick(); rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick(); jmpValid = 1; jmpTarget = 16'h0200;
      tick(); jmpValid = 0;
    end
    @(negedge clk);
`ifdef BR_STATS_EN
    exp_cnt = 16'd3;
`else
    exp_cnt = 16'd0;
`endif
    chk("t6_taken", 32'(taken_cnt), 32'(exp_cnt));

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
